load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory; translates MIPS byte/halfword/word loads and stores into whole-word memory accesses.
- Loads: extracts the addressed byte lane and sign- or zero-extends it.
- Sub-word stores: read-modify-write (read, merge, write) because the memory writes whole words only.
- Checks alignment, range and op size; faulting requests never touch memory.

Parameters:
- DATA_WIDTH, 32, data word width (fixed 32 for lane logic)
- ADDR_WIDTH, 32, byte address width
- MEM_WORDS, 32, number of words in the data memory

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- Req  in  1  request valid; accepted when Req && !Busy
- Write  in  1  1 = store, 0 = load
- Op  in  3  load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: Op[1:0] 00 byte, 01 half, 10 word, Op[2] ignored
- Addr  in  32  byte address
- StoreData  in  32  store data, right-justified
- Busy  out  1  high while in RMW_WRITE; no new request accepted
- Done  out  1  one-cycle registered completion pulse
- Fault  out  1  valid with Done; 1 = request rejected
- LoadData  out  32  registered, extended load result
- MemAddr  out  32  word index to memory = {2'b00, Addr[31:2]} (latched Addr in RMW_WRITE)
- MemWriteData  out  32  word to memory
- MemWrite  out  1  memory write enable; memory writes on the Clk edge
- MemRead  out  1  memory read enable
- MemDataRead  in  32  memory read data, combinational from MemAddr

Behaviour:
- Little-endian lanes: byte k = bits 8k+7:8k; half 0 = 15:0, half 1 = 31:16.
- Fault conditions, evaluated combinationally at acceptance:
  - half with Addr[0] = 1; word with Addr[1:0] != 0
  - Addr[31:2] >= MEM_WORDS
  - Op[1:0] = 11; load Op 110/111
- Fault path: MemRead = MemWrite = 0; next edge Done = 1, Fault = 1, LoadData unchanged.
- FSM states: IDLE, RMW_WRITE. Busy = (state == RMW_WRITE).
- IDLE, accepted load: MemRead = 1 same cycle. Next edge: LoadData = extended lane, Done = 1, Fault = 0. Latency 1, stays IDLE.
- IDLE, accepted SW: MemWrite = 1, MemWriteData = StoreData same cycle. Next edge: Done = 1. Stays IDLE.
- IDLE, accepted SB/SH:
  - Same cycle: MemRead = 1.
  - Next edge: capture merge = MemDataRead with addressed lane replaced by StoreData[7:0] or [15:0]; latch word address; go to RMW_WRITE.
- RMW_WRITE: MemWrite = 1, MemWriteData = merge word, MemAddr = latched address; Req ignored. Next edge: Done = 1, go to IDLE. Total latency 2.
- Done is high exactly one cycle per accepted request. A new request may be accepted in the cycle Done is high (back-to-back, one per cycle for loads and SW).
- Req while Busy is neither queued nor lost; the requester holds Req until accepted.
- MemRead and MemWrite are never both high.
- Reset (async):
  - state = IDLE; Done = Fault = 0; LoadData = 0; merge and latched address cleared.
  - MemRead, MemWrite, MemAddr, MemWriteData = 0 while Reset is high.
  - Reset during RMW_WRITE aborts the write: MemWrite drops immediately, memory is not modified, no Done pulse.
- Extension: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word.

Test Plan:
- mem[3] = 32'h8899AABB; LB Addr = 0x0D -> MemAddr = 3, next cycle LoadData = 32'hFFFFFFAA, Done = 1, Fault = 0; LBU Addr = 0x0D -> 32'h000000AA.
- SB Addr = 0x0E, StoreData = 32'h00000055, mem[3] = 32'h8899AABB -> cycle 1 MemRead = 1; cycle 2 Busy = 1, MemWrite = 1, MemWriteData = 32'h8855AABB; Done on next cycle.
- LH Addr = 0x0B -> no MemRead, Done = 1, Fault = 1, LoadData unchanged; LW Addr = 0x80 (word 32) -> Fault = 1.
- Reset asserted mid RMW_WRITE of SH Addr = 0x04 -> MemWrite falls immediately, mem[1] unchanged, no Done pulse, Busy = 0.
- Back-to-back LW 0x00, LW 0x04, SW 0x08 on consecutive cycles -> three Done pulses on consecutive cycles, Busy never asserted.
- Req held high during RMW_WRITE with LW 0x10 -> LW accepted only the cycle after Busy falls; Done for the SH and for the LW each pulse once.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Sub-word stores are read-modify-write; faulting requests never touch memory.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Req,
  input  logic                  Write,
  input  logic [2:0]            Op,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] StoreData,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Fault,
  output logic [DATA_WIDTH-1:0] LoadData,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [DATA_WIDTH-1:0] MemWriteData,
  output logic                  MemWrite,
  output logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] MemDataRead
);

  typedef enum logic {IDLE, RMW_WRITE} state_e;

  localparam logic [ADDR_WIDTH-3:0] WORD_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  state_e                state_q;
  logic                  done_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] load_data_q;
  logic [DATA_WIDTH-1:0] merge_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [1:0]            size;
  logic                  req_fault;
  logic                  accept;
  logic                  go;
  logic                  is_rmw;
  logic [4:0]            byte_lo;
  logic [4:0]            half_lo;
  logic [7:0]            lane_byte;
  logic [15:0]           lane_half;
  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] merge_d;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign size      = Op[1:0];
  assign word_addr = {2'b00, Addr[ADDR_WIDTH-1:2]};
  assign byte_lo   = {Addr[1:0], 3'b000};
  assign half_lo   = {Addr[1], 4'b0000};
  assign lane_byte = MemDataRead[byte_lo +: 8];
  assign lane_half = MemDataRead[half_lo +: 16];

  always_comb begin
    req_fault = 1'b0;
    if (size == 2'b11) req_fault = 1'b1;
    if (!Write && Op == 3'b110) req_fault = 1'b1;
    if (size == 2'b01 && Addr[0]) req_fault = 1'b1;
    if (size == 2'b10 && Addr[1:0] != 2'b00) req_fault = 1'b1;
    if (Addr[ADDR_WIDTH-1:2] >= WORD_LIMIT) req_fault = 1'b1;
  end

  assign Busy   = (state_q == RMW_WRITE);
  assign accept = Req && (state_q == IDLE);
  assign go     = accept && !req_fault;
  assign is_rmw = go && Write && (size != 2'b10);

  always_comb begin
    case (Op)
      3'b000:  load_ext = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_ext = {{16{lane_half[15]}}, lane_half};
      3'b100:  load_ext = {24'h000000, lane_byte};
      3'b101:  load_ext = {16'h0000, lane_half};
      default: load_ext = MemDataRead;
    endcase
  end

  always_comb begin
    merge_d = MemDataRead;
    if (size == 2'b00) merge_d[byte_lo +: 8] = StoreData[7:0];
    else               merge_d[half_lo +: 16] = StoreData[15:0];
  end

  // Memory-side strobes are combinational so the memory sees them in the
  // acceptance cycle; Reset forces them low so an aborted RMW never writes.
  assign MemRead      = !Reset && go && (!Write || size != 2'b10);
  assign MemWrite     = !Reset && (Busy || (go && Write && size == 2'b10));
  assign MemAddr      = Reset ? '0 : (Busy ? addr_q : word_addr);
  assign MemWriteData = Reset ? '0 : (Busy ? merge_q : StoreData);

  assign Done     = done_q;
  assign Fault    = fault_q;
  assign LoadData = load_data_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      load_data_q <= '0;
      merge_q     <= '0;
      addr_q      <= '0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (req_fault) begin
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else if (is_rmw) begin
              merge_q <= merge_d;
              addr_q  <= word_addr;
              state_q <= RMW_WRITE;
            end else begin
              done_q <= 1'b1;
              if (!Write) load_data_q <= load_ext;
            end
          end
        end
        RMW_WRITE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: requests push expected Done responses,
// a negedge monitor pops and compares them.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req;
  logic        Write;
  logic [2:0]  Op;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic        Busy;
  logic        Done;
  logic        Fault;
  logic [31:0] LoadData;
  logic [31:0] MemAddr;
  logic [31:0] MemWriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] MemDataRead;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(32)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Write(Write), .Op(Op), .Addr(Addr),
    .StoreData(StoreData), .Busy(Busy), .Done(Done), .Fault(Fault),
    .LoadData(LoadData), .MemAddr(MemAddr), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemDataRead(MemDataRead)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic        fault;
    logic [31:0] ld;
  } exp_t;

  exp_t        sb[$];
  int          done_times[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          busy_count = 0;
  logic [31:0] last_ld = 32'h0;
  logic        preload = 1'b1;
  logic [31:0] mem [0:31];

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'hDEADBEEF;
      1:       return 32'h11223344;
      2:       return 32'h00000000;
      3:       return 32'h8899AABB;
      4:       return 32'hCAFEF00D;
      default: return 32'h10000000 | i;
    endcase
  endfunction

  assign MemDataRead = (MemAddr < 32) ? mem[MemAddr[4:0]] : 32'h0;

  always @(posedge Clk) begin
    cycle <= cycle + 1;
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (MemWrite && MemAddr < 32) begin
      mem[MemAddr[4:0]] <= MemWriteData;
    end
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    if (MemRead && MemWrite) check("rd_wr_exclusive", 32'd1, 32'd0);
    if (Busy) busy_count++;
    if (Done) begin
      done_times.push_back(cycle);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("done_fault", {31'd0, Fault}, {31'd0, e.fault});
        check("done_loaddata", LoadData, e.ld);
        $display("[TB] t=%0t done fault=%0b loaddata=%h", $time, Fault, LoadData);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drive one request and hold it until accepted; entered and left at posedge+1.
  task automatic do_req(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] sd, input logic exp_fault, input logic upd,
                        input logic [31:0] ld, input logic exp_rd, input logic exp_wr,
                        input logic push, output int waits);
    Req = 1'b1; Write = wr; Op = op; Addr = addr; StoreData = sd;
    waits = 0;
    forever begin
      @(negedge Clk);
      if (!Busy) break;
      waits++;
      if (waits > 20) begin
        check("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    if (upd) last_ld = ld;
    if (push) sb.push_back('{exp_fault, last_ld});
    check("memread", {31'd0, MemRead}, {31'd0, exp_rd});
    check("memwrite", {31'd0, MemWrite}, {31'd0, exp_wr});
    if (exp_rd || exp_wr) check("memaddr", MemAddr, {2'b00, addr[31:2]});
    if (exp_wr) check("memwdata", MemWriteData, sd);
    @(posedge Clk); #1;
    Req = 1'b0;
  endtask

  initial begin
    int w;
    int n0;
    int b0;
    Reset = 1'b1; Req = 1'b1; Write = 1'b0; Op = 3'b000;
    Addr = 32'h0000000D; StoreData = 32'hA5A5A5A5;
    repeat (2) @(negedge Clk);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_fault", {31'd0, Fault}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_loaddata", LoadData, 32'h0);
    check("rst_memread", {31'd0, MemRead}, 32'd0);
    check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
    check("rst_memaddr", MemAddr, 32'h0);
    check("rst_memwdata", MemWriteData, 32'h0);
    @(posedge Clk); #1;
    Reset = 1'b0; preload = 1'b0; Req = 1'b0;

    // Loads from mem[3] = 8899AABB
    do_req(1'b0, 3'b000, 32'h0D, 32'h0, 1'b0, 1'b1, 32'hFFFFFFAA, 1'b1, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b100, 32'h0D, 32'h0, 1'b0, 1'b1, 32'h000000AA, 1'b1, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b001, 32'h0E, 32'h0, 1'b0, 1'b1, 32'hFFFF8899, 1'b1, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b101, 32'h0C, 32'h0, 1'b0, 1'b1, 32'h0000AABB, 1'b1, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 1'b1, 32'h8899AABB, 1'b1, 1'b0, 1'b1, w);

    // SB into lane 2 of mem[3]
    do_req(1'b1, 3'b000, 32'h0E, 32'h55, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, w);
    @(negedge Clk);
    check("rmw_busy", {31'd0, Busy}, 32'd1);
    check("rmw_memwrite", {31'd0, MemWrite}, 32'd1);
    check("rmw_memread", {31'd0, MemRead}, 32'd0);
    check("rmw_memaddr", MemAddr, 32'd3);
    check("rmw_wdata", MemWriteData, 32'h8855AABB);
    @(posedge Clk); #1;
    do_req(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 1'b1, 32'h8855AABB, 1'b1, 1'b0, 1'b1, w);

    // Faulting requests: no memory access, LoadData unchanged
    do_req(1'b0, 3'b001, 32'h0B, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b010, 32'h80, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b1, 3'b010, 32'h02, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b011, 32'h00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b110, 32'h00, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b1, 3'b001, 32'h01, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b1, 3'b000, 32'h80, 32'h1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b010, 32'h7C, 32'h0, 1'b0, 1'b1, 32'h1000001F, 1'b1, 1'b0, 1'b1, w);

    // Back-to-back LW, LW, SW
    n0 = done_times.size() + 1;
    b0 = busy_count;
    do_req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, w);
    n0 = done_times.size();
    do_req(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b1, w);
    do_req(1'b1, 3'b010, 32'h08, 32'h12345678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, w);
    repeat (2) @(negedge Clk);
    check("b2b_done_count", done_times.size() - n0, 32'd3);
    if (done_times.size() >= n0 + 3) begin
      check("b2b_gap1", done_times[n0+1] - done_times[n0], 32'd1);
      check("b2b_gap2", done_times[n0+2] - done_times[n0+1], 32'd1);
    end
    check("b2b_no_busy", busy_count - b0, 32'd0);
    @(posedge Clk); #1;
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1, w);

    // SH to half 1 of mem[4], LW held during RMW_WRITE
    do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, w);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 1'b1, 32'hBEEFF00D, 1'b1, 1'b0, 1'b1, w);
    check("held_wait_cycles", w, 32'd1);

    // Reset during RMW_WRITE aborts the write
    do_req(1'b1, 3'b001, 32'h04, 32'h0000AAAA, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, w);
    check("abort_pre_memwrite", {31'd0, MemWrite}, 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("abort_memwrite", {31'd0, MemWrite}, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    check("abort_done", {31'd0, Done}, 32'd0);
    @(posedge Clk); #1;
    check("abort_mem1", mem[1], 32'h11223344);
    check("abort_loaddata", LoadData, 32'h0);
    Reset = 1'b0;
    last_ld = 32'h0;
    @(negedge Clk);
    check("abort_no_done", {31'd0, Done}, 32'd0);
    @(posedge Clk); #1;
    do_req(1'b0, 3'b010, 32'h04, 32'h0, 1'b0, 1'b1, 32'h11223344, 1'b1, 1'b0, 1'b1, w);

    repeat (3) @(negedge Clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
